// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and
// the opcode constants the datapath and FSM key off.
// No ports (package).
package alu_mc_pkg;

   typedef enum logic [3:0] {
      ADDU  = 4'd0,
      ADDS  = 4'd1,
      SUBU  = 4'd2,
      SUBS  = 4'd3,
      AND   = 4'd4,
      OR    = 4'd5,
      XOR   = 4'd6,
      SRL1  = 4'd7,
      SLL   = 4'd8,
      SRL   = 4'd9,
      SRA   = 4'd10,
      SLTU  = 4'd11,
      SLT   = 4'd12,
      MULU  = 4'd13,
      RSV14 = 4'd14,
      RSV15 = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam op_e MULU_OP = MULU;
   localparam op_e RSV_LO  = RSV14;

   // Opcodes 14 and 15 are reserved and flagged as illegal.
   function automatic logic is_reserved(input op_e op);
      return op >= RSV_LO;
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/writeback bus of the multi-cycle ALU.
//  in_valid/in_ready/A/B/opcode : issue-side handshake and operands
//  out_valid/out_ready          : writeback-side handshake
//  result/result_hi             : low word / high product word
//  carryout/overflow/zero/negative/illegal : result flags
// master = issue/writeback side, slave = the ALU.
interface alu_mc_if #(
   parameter int NUMBITS = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [NUMBITS-1:0] A;
   logic [NUMBITS-1:0] B;
   logic [3:0]         opcode;
   logic               out_valid;
   logic               out_ready;
   logic [NUMBITS-1:0] result;
   logic [NUMBITS-1:0] result_hi;
   logic               carryout;
   logic               overflow;
   logic               zero;
   logic               negative;
   logic               illegal;

   modport master (
      output in_valid, A, B, opcode, out_ready,
      input  in_ready, out_valid, result, result_hi,
             carryout, overflow, zero, negative, illegal
   );

   modport slave (
      input  in_valid, A, B, opcode, out_ready,
      output in_ready, out_valid, result, result_hi,
             carryout, overflow, zero, negative, illegal
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
//  clk, reset : clock, synchronous active-high reset (aborts a multiply)
//  start      : load a/b and begin; takes NUMBITS cycles
//  a, b       : operands, sampled only on start
//  done       : one-cycle pulse when product is complete
//  product    : 2*NUMBITS-bit result, valid while done is high
module alu_mul_iter #(
   parameter int NUMBITS = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUMBITS-1:0]     a,
   input  logic [NUMBITS-1:0]     b,
   output logic                   done,
   output logic [2*NUMBITS-1:0]   product
);
   localparam int SHW = $clog2(NUMBITS);
   localparam logic [SHW-1:0] LAST = SHW'(NUMBITS - 1);

   logic [NUMBITS-1:0]   mcand;
   logic [SHW-1:0]       cnt;
   logic                 busy;
   logic [2*NUMBITS-1:0] p;
   logic [NUMBITS:0]     sum;

   // Upper half accumulates; lower half starts as the multiplier and is
   // consumed LSB-first as the whole register shifts right.
   always_comb begin
      sum = {1'b0, p[2*NUMBITS-1:NUMBITS]} + (p[0] ? {1'b0, mcand} : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
         p     <= '0;
         mcand <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            p     <= {{NUMBITS{1'b0}}, b};
            mcand <= a;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (busy) begin
            p   <= {sum, p[NUMBITS-1:1]};
            cnt <= cnt + SHW'(1);
            if (cnt == LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign product = p;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU holding one operation in flight.
//  clk   : clock, rising edge
//  reset : synchronous active-high reset
//  bus   : alu_mc_if slave (operands/opcode in with valid/ready,
//          registered result/flags out with valid/ready)
// Single-cycle ops complete one cycle after accept; MULU runs on the
// iterative multiplier and completes NUMBITS+1 cycles after accept.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int NUMBITS = 32
) (
   input logic     clk,
   input logic     reset,
   alu_mc_if.slave bus
);
   localparam int SHW = $clog2(NUMBITS);
   localparam int MSB = NUMBITS - 1;

   logic [NUMBITS-1:0] a, b;
   logic [SHW-1:0]     sh;
   op_e                op;

   assign a  = bus.A;
   assign b  = bus.B;
   assign sh = b[SHW-1:0];
   assign op = op_e'(bus.opcode);

   // Single-cycle op unit
   logic [NUMBITS-1:0] r;
   logic               c, v, ill;

   always_comb begin
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      ill = 1'b0;
      case (op)
         ADDU: {c, r} = {1'b0, a} + {1'b0, b};
         ADDS: begin
            r = a + b;
            v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
         end
         SUBU: {c, r} = {1'b0, a} - {1'b0, b};
         SUBS: begin
            r = a - b;
            v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
         end
         AND:  r = a & b;
         OR:   r = a | b;
         XOR:  r = a ^ b;
         SRL1: r = a >> 1;
         SLL:  r = a << sh;
         SRL:  r = a >> sh;
         SRA:  r = $signed(a) >>> sh;
         SLTU: r = {{(NUMBITS-1){1'b0}}, (a < b)};
         SLT:  r = {{(NUMBITS-1){1'b0}}, ($signed(a) < $signed(b))};
         MULU: r = '0;
         default: ill = is_reserved(op);
      endcase
   end

   // Multiplier
   state_e               state;
   logic                 in_ready, accept, mul_start, mul_done;
   logic [2*NUMBITS-1:0] product;
   logic [NUMBITS-1:0]   prod_lo, prod_hi;

   assign in_ready  = (state == IDLE) || ((state == OUT) && bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign mul_start = accept && (op == MULU_OP);
   assign prod_lo   = product[NUMBITS-1:0];
   assign prod_hi   = product[2*NUMBITS-1:NUMBITS];

   alu_mul_iter #(.NUMBITS(NUMBITS)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );

   // FSM and output registers
   logic               valid_q, c_q, v_q, z_q, n_q, ill_q;
   logic [NUMBITS-1:0] res_q, hi_q;

   // Accept is checked first so a drain in OUT can chain straight into
   // the next operation in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         valid_q <= 1'b0;
         res_q   <= '0;
         hi_q    <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         ill_q   <= 1'b0;
      end else if (accept) begin
         if (op == MULU_OP) begin
            state   <= BUSY;
            valid_q <= 1'b0;
         end else begin
            state   <= OUT;
            valid_q <= 1'b1;
            res_q   <= r;
            hi_q    <= '0;
            c_q     <= c;
            v_q     <= v;
            z_q     <= (r == '0);
            n_q     <= r[MSB];
            ill_q   <= ill;
         end
      end else begin
         case (state)
            BUSY: if (mul_done) begin
               state   <= OUT;
               valid_q <= 1'b1;
               res_q   <= prod_lo;
               hi_q    <= prod_hi;
               c_q     <= |prod_hi;
               v_q     <= 1'b0;
               z_q     <= (prod_lo == '0);
               n_q     <= prod_lo[MSB];
               ill_q   <= 1'b0;
            end
            OUT: if (bus.out_ready) begin
               state   <= IDLE;
               valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.result    = res_q;
   assign bus.result_hi = hi_q;
   assign bus.carryout  = c_q;
   assign bus.overflow  = v_q;
   assign bus.zero      = z_q;
   assign bus.negative  = n_q;
   assign bus.illegal   = ill_q;

endmodule
